// File: rtl/video_timing_gen.sv
// Raster timing generator: requests pixels by (h_pos, v_pos) and realigns DE/syncs/SOF with the returned data.
// Latency: request one cycle after the counter state; vid_* appear PIPE_LAT+1 cycles after the matching req.
// Backpressure: none; en=0 idles the raster and flushes every pipeline stage on the same edge.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned DATA_W   = 24
) (
  input  logic              clk_pix,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic              req,
  output logic [CNT_W-1:0]  h_pos,
  output logic [CNT_W-1:0]  v_pos,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_de,
  output logic              vid_hsync,
  output logic              vid_vsync,
  output logic              vid_sof
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned NST     = PIPE_LAT + 1;

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Syncs are carried active-high internally; polarity is applied only at the pins.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic sof;
  } ctl_t;

  logic [CNT_W-1:0]  h_q, h_d;
  logic [CNT_W-1:0]  v_q, v_d;
  logic              req_q, req_d;
  logic [CNT_W-1:0]  h_pos_q, h_pos_d;
  logic [CNT_W-1:0]  v_pos_q, v_pos_d;
  ctl_t              req_ctl_q, req_ctl_d;
  ctl_t [NST-1:0]    pipe_q, pipe_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;

  logic act, hs_reg, vs_reg;

  // Region decode of the pixel about to be requested.
  always_comb begin
    act    = (h_q < H_ACT) && (v_q < V_ACT);
    hs_reg = (h_q >= HS_BEG) && (h_q < HS_END);
    vs_reg = (v_q >= VS_BEG) && (v_q < VS_END);
  end

  // Next-state: raster counters, request stage, delay line and data capture; en=0 idles all of it.
  always_comb begin
    h_d        = '0;
    v_d        = '0;
    req_d      = 1'b0;
    h_pos_d    = '0;
    v_pos_d    = '0;
    req_ctl_d  = '0;
    pipe_d     = '0;
    vid_data_d = '0;
    if (en) begin
      req_d         = act;
      h_pos_d       = act ? h_q : '0;
      v_pos_d       = act ? v_q : '0;
      req_ctl_d.de  = act;
      req_ctl_d.hs  = hs_reg;
      req_ctl_d.vs  = vs_reg;
      req_ctl_d.sof = act && (h_q == '0) && (v_q == '0);
      pipe_d[0]     = req_ctl_q;
      for (int i = 1; i < int'(NST); i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
      // The DE entering the last stage belongs to the pixel whose data is on data_in now.
      vid_data_d = pipe_d[NST-1].de ? data_in : '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
  end

  // State registers; reset returns everything to the idle raster immediately.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      h_q        <= '0;
      v_q        <= '0;
      req_q      <= 1'b0;
      h_pos_q    <= '0;
      v_pos_q    <= '0;
      req_ctl_q  <= '0;
      pipe_q     <= '0;
      vid_data_q <= '0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      req_q      <= req_d;
      h_pos_q    <= h_pos_d;
      v_pos_q    <= v_pos_d;
      req_ctl_q  <= req_ctl_d;
      pipe_q     <= pipe_d;
      vid_data_q <= vid_data_d;
    end
  end

  assign req       = req_q;
  assign h_pos     = h_pos_q;
  assign v_pos     = v_pos_q;
  assign vid_data  = vid_data_q;
  assign vid_de    = pipe_q[NST-1].de;
  assign vid_sof   = pipe_q[NST-1].sof;
  assign vid_hsync = pipe_q[NST-1].hs ? HS_POL : ~HS_POL;
  assign vid_vsync = pipe_q[NST-1].vs ? VS_POL : ~VS_POL;

endmodule
